// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter: FSM state encoding,
// requester identifiers and the width of the BUSY-cycle timeout counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Wide enough for the largest legal TIMEOUT of 65535
  localparam int CNT_W = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way grant picker: a lone requester always wins; on a tie the grant
// goes to whichever requester was not the last one served.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cReq_i,
  input  logic dReq_i,
  input  logic lastOwner_i,
  output logic winner_o,
  output logic valid_o
);

  always_comb begin
    valid_o  = cReq_i | dReq_i;
    winner_o = OWN_CPU;
    if (dReq_i && !cReq_i) begin
      winner_o = OWN_DMA;
    end else if (cReq_i && dReq_i && (lastOwner_i == OWN_CPU)) begin
      winner_o = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a DMA requester onto one memory port, with a per-transaction
// timeout. Define MEM_ARB_RR_EN for round-robin ties; otherwise the CPU wins every tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_ren,
  input  logic              c_wen,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_bsel,
  output logic [31:0]       c_rdata,
  output logic              c_ready,
  output logic              c_err,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_bsel,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_bsel,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              owner
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;
  logic              mem_ren_q;
  logic              mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_bsel_q;
  logic [31:0]       c_rdata_q;
  logic              c_ready_q;
  logic              c_err_q;
  logic [31:0]       d_rdata_q;
  logic              d_ready_q;
  logic              d_err_q;

  logic cReq;
  logic dReq;
  logic lastOwner;
  logic pickWinner;
  logic pickValid;
  logic busyDone;

  assign cReq     = c_ren | c_wen;
  assign dReq     = d_ren | d_wen;
  assign busyDone = (state_q == BUSY) && (mem_ready || (cnt_q == CNT_LAST));

  mem_arb_pick uPick (
    .cReq_i      (cReq),
    .dReq_i      (dReq),
    .lastOwner_i (lastOwner),
    .winner_o    (pickWinner),
    .valid_o     (pickValid)
  );

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Pointer starts at DMA so the CPU takes the first tie after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= OWN_DMA;
    end else if (busyDone) begin
      last_q <= owner_q;
    end
  end

  assign lastOwner = last_q;
`else
  assign lastOwner = OWN_DMA;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_CPU;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bsel_q  <= '0;
      c_rdata_q   <= '0;
      c_ready_q   <= 1'b0;
      c_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      c_ready_q <= 1'b0;
      c_err_q   <= 1'b0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
      case (state_q)
        // The payload is latched here, so later requester changes cannot disturb it
        IDLE: begin
          if (pickValid) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            owner_q <= pickWinner;
            if (pickWinner == OWN_DMA) begin
              mem_wen_q   <= d_wen;
              mem_ren_q   <= d_ren & ~d_wen;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_bsel_q  <= d_bsel;
            end else begin
              mem_wen_q   <= c_wen;
              mem_ren_q   <= c_ren & ~c_wen;
              mem_addr_q  <= c_addr;
              mem_wdata_q <= c_wdata;
              mem_bsel_q  <= c_bsel;
            end
          end
        end
        BUSY: begin
          if (busyDone) begin
            state_q   <= RESP;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            if (owner_q == OWN_DMA) begin
              d_ready_q <= mem_ready;
              d_err_q   <= ~mem_ready;
              if (mem_ready) d_rdata_q <= mem_rdata;
            end else begin
              c_ready_q <= mem_ready;
              c_err_q   <= ~mem_ready;
              if (mem_ready) c_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign owner     = owner_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_bsel  = mem_bsel_q;
  assign c_rdata   = c_rdata_q;
  assign c_ready   = c_ready_q;
  assign c_err     = c_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: expected responses are queued when a request
// is driven and popped when the DUT answers. Tie expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_ren, c_wen, d_ren, d_wen;
  logic [AW-1:0] c_addr, d_addr;
  logic [31:0]   c_wdata, d_wdata;
  logic [3:0]    c_bsel, d_bsel;
  logic [31:0]   c_rdata, d_rdata;
  logic          c_ready, c_err, d_ready, d_err;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_bsel;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          owner;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .c_ren(c_ren), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata), .c_bsel(c_bsel),
    .c_rdata(c_rdata), .c_ready(c_ready), .c_err(c_err),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_bsel(d_bsel),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bsel(mem_bsel), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  typedef struct packed {
    logic          own;
    logic          err;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cyc     = 0;
  logic lastModel;

  // Scratch shared by the sequentially called scenario tasks
  exp_t          e;
  logic          seen, held, got, rd, wr, own, cr, ce, dr, de;
  logic [AW-1:0] addr;
  logic [31:0]   wdata, crd, drd, obsRd;
  logic [3:0]    bsel;
  logic [4:0]    expFlags;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d expected below 30000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference arbitration: a lone requester wins, ties depend on the build option
  function automatic logic pickModel(input logic cq, input logic dq);
    if (cq && !dq) return OWN_CPU;
    if (dq && !cq) return OWN_DMA;
`ifdef MEM_ARB_RR_EN
    return (lastModel == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
    return OWN_CPU;
`endif
  endfunction

  task automatic applyReset();
    c_ren = 0; c_wen = 0; c_addr = '0; c_wdata = '0; c_bsel = '0;
    d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_bsel = '0;
    mem_ready = 0; mem_rdata = '0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    lastModel = OWN_DMA;
    expQ.delete();
  endtask

  // Waits for a memory command, captures it, then answers after 'delay' cycles (never if negative)
  task automatic serveMem(input int delay, input logic [31:0] data);
    seen = 0; held = 1; rd = 0; wr = 0; own = 0; addr = '0; wdata = '0; bsel = '0;
    for (int i = 0; i < 50; i++) begin
      if (mem_ren || mem_wen) begin
        seen = 1; rd = mem_ren; wr = mem_wen; own = owner;
        addr = mem_addr; wdata = mem_wdata; bsel = mem_bsel;
        break;
      end
      @(negedge clk);
    end
    if (seen && delay >= 0) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        if (mem_ren !== rd || mem_wen !== wr || mem_addr !== addr) held = 0;
      end
      mem_ready = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
    end
  endtask

  task automatic waitResp();
    got = 0; cr = 0; ce = 0; dr = 0; de = 0; crd = '0; drd = '0;
    for (int i = 0; i < 40; i++) begin
      if (c_ready || c_err || d_ready || d_err) begin
        got = 1; cr = c_ready; ce = c_err; dr = d_ready; de = d_err;
        crd = c_rdata; drd = d_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    c_ren = 1; d_wen = 1; c_addr = 32'hFFFF_FFFC; d_addr = 32'h1234_0000;
    c_wen = 0; d_ren = 0; c_wdata = '1; d_wdata = '1; c_bsel = '1; d_bsel = '1;
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    reset = 1;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({mem_ren, mem_wen, c_ready, c_err, d_ready, d_err, owner} !== 7'b0) begin
      nFails++;
      $display("[TB] FAIL reset_ctrl: ren/wen/cr/ce/dr/de/own=%b expected 0000000",
               {mem_ren, mem_wen, c_ready, c_err, d_ready, d_err, owner});
    end
    nChecks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_bsel !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_payload: addr=%h wdata=%h bsel=%h expected all 0", mem_addr, mem_wdata, mem_bsel);
    end
    nChecks++;
    if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset_rdata: c_rdata=%h d_rdata=%h expected 0", c_rdata, d_rdata);
    end
    applyReset();
    @(negedge clk);
    nChecks++;
    if ({mem_ren, mem_wen} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL reset_idle: ren/wen=%b expected 00", {mem_ren, mem_wen});
    end
  endtask

  task automatic test_cpu_read();
    applyReset();
    c_ren = 1; c_addr = 32'h100; c_bsel = 4'hF;
    expQ.push_back(exp_t'{own: OWN_CPU, err: 1'b0, wr: 1'b0, addr: 32'h100, wdata: 32'h0, rdata: 32'hDEAD_BEEF});
    serveMem(2, 32'hDEAD_BEEF);
    nChecks++;
    if (seen !== 1'b1 || {rd, wr} !== 2'b10 || addr !== expQ[0].addr || own !== expQ[0].own) begin
      nFails++;
      $display("[TB] FAIL read_cmd: seen=%b rd/wr=%b addr=%h own=%b expected 1 10 %h %b",
               seen, {rd, wr}, addr, own, expQ[0].addr, expQ[0].own);
    end
    nChecks++;
    if (held !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL read_hold: command held=%b expected 1", held);
    end
    waitResp();
    c_ren = 0;
    e = expQ.pop_front();
    expFlags = {1'b1, (e.own == OWN_CPU) && !e.err, (e.own == OWN_CPU) && e.err,
                      (e.own == OWN_DMA) && !e.err, (e.own == OWN_DMA) && e.err};
    nChecks++;
    if ({got, cr, ce, dr, de} !== expFlags) begin
      nFails++;
      $display("[TB] FAIL read_resp: got/cr/ce/dr/de=%b expected %b", {got, cr, ce, dr, de}, expFlags);
    end
    obsRd = (e.own == OWN_CPU) ? crd : drd;
    nChecks++;
    if (obsRd !== e.rdata) begin
      nFails++;
      $display("[TB] FAIL read_rdata: got %h expected %h", obsRd, e.rdata);
    end
    @(negedge clk);
    nChecks++;
    if ({c_ready, d_ready, mem_ren} !== 3'b000 || c_rdata !== 32'hDEAD_BEEF) begin
      nFails++;
      $display("[TB] FAIL read_after: cr/dr/ren=%b c_rdata=%h expected 000 deadbeef",
               {c_ready, d_ready, mem_ren}, c_rdata);
    end
  endtask

  task automatic test_cpu_write();
    int cycReq;
    applyReset();
    c_ren = 1; c_wen = 1; c_addr = 32'h200; c_wdata = 32'h1234_5678; c_bsel = 4'hF;
    cycReq = cyc;
    expQ.push_back(exp_t'{own: OWN_CPU, err: 1'b0, wr: 1'b1, addr: 32'h200, wdata: 32'h1234_5678, rdata: 32'h0BAD_F00D});
    serveMem(0, 32'h0BAD_F00D);
    nChecks++;
    if (seen !== 1'b1 || {rd, wr} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL write_kind: seen=%b rd/wr=%b expected 1 01", seen, {rd, wr});
    end
    nChecks++;
    if (wdata !== expQ[0].wdata || bsel !== 4'hF || addr !== expQ[0].addr) begin
      nFails++;
      $display("[TB] FAIL write_payload: wdata=%h bsel=%h addr=%h expected %h f %h",
               wdata, bsel, addr, expQ[0].wdata, expQ[0].addr);
    end
    waitResp();
    c_ren = 0; c_wen = 0;
    e = expQ.pop_front();
    nChecks++;
    if ((cyc - cycReq + 1) !== 3) begin
      nFails++;
      $display("[TB] FAIL write_latency: %0d cycles expected 3", cyc - cycReq + 1);
    end
    expFlags = {1'b1, (e.own == OWN_CPU) && !e.err, (e.own == OWN_CPU) && e.err,
                      (e.own == OWN_DMA) && !e.err, (e.own == OWN_DMA) && e.err};
    nChecks++;
    if ({got, cr, ce, dr, de} !== expFlags || crd !== e.rdata) begin
      nFails++;
      $display("[TB] FAIL write_resp: flags=%b rdata=%h expected %b %h", {got, cr, ce, dr, de}, crd, expFlags, e.rdata);
    end
  endtask

  task automatic test_tie();
    logic w;
    applyReset();
    c_wen = 1; c_addr = 32'h300; c_wdata = 32'hC0C0_C0C0; c_bsel = 4'h3;
    d_wen = 1; d_addr = 32'h400; d_wdata = 32'hD0D0_D0D0; d_bsel = 4'hC;
    for (int i = 0; i < 3; i++) begin
      w = pickModel(1'b1, 1'b1);
      lastModel = w;
      expQ.push_back(exp_t'{own: w, err: 1'b0, wr: 1'b1,
                            addr: (w == OWN_CPU) ? 32'h300 : 32'h400,
                            wdata: (w == OWN_CPU) ? 32'hC0C0_C0C0 : 32'hD0D0_D0D0,
                            rdata: 32'h1000 + 32'(i)});
    end
    for (int i = 0; i < 3; i++) begin
      serveMem(1, 32'h1000 + 32'(i));
      nChecks++;
      if (seen !== 1'b1 || own !== expQ[0].own || addr !== expQ[0].addr || wdata !== expQ[0].wdata) begin
        nFails++;
        $display("[TB] FAIL tie_grant%0d: seen=%b own=%b addr=%h wdata=%h expected 1 %b %h %h",
                 i, seen, own, addr, wdata, expQ[0].own, expQ[0].addr, expQ[0].wdata);
      end
      waitResp();
      if (i == 2) begin
        c_wen = 0; d_wen = 0;
      end
      e = expQ.pop_front();
      expFlags = {1'b1, (e.own == OWN_CPU) && !e.err, (e.own == OWN_CPU) && e.err,
                        (e.own == OWN_DMA) && !e.err, (e.own == OWN_DMA) && e.err};
      obsRd = (e.own == OWN_CPU) ? crd : drd;
      nChecks++;
      if ({got, cr, ce, dr, de} !== expFlags || obsRd !== e.rdata) begin
        nFails++;
        $display("[TB] FAIL tie_resp%0d: flags=%b rdata=%h expected %b %h",
                 i, {got, cr, ce, dr, de}, obsRd, expFlags, e.rdata);
      end
    end
    repeat (2) @(negedge clk);
    nChecks++;
    if ({mem_ren, mem_wen} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL tie_idle: ren/wen=%b expected 00", {mem_ren, mem_wen});
    end
  endtask

  task automatic test_timeout();
    int   errAt;
    logic early, renAtErr;
    applyReset();
    d_ren = 1; d_addr = 32'h500; d_bsel = 4'hF;
    expQ.push_back(exp_t'{own: OWN_DMA, err: 1'b0, wr: 1'b0, addr: 32'h500, wdata: 32'h0, rdata: 32'h5555_AAAA});
    serveMem(1, 32'h5555_AAAA);
    nChecks++;
    if (seen !== 1'b1 || own !== OWN_DMA || addr !== expQ[0].addr) begin
      nFails++;
      $display("[TB] FAIL dma_cmd: seen=%b own=%b addr=%h expected 1 1 %h", seen, own, addr, expQ[0].addr);
    end
    waitResp();
    d_ren = 0;
    e = expQ.pop_front();
    nChecks++;
    if ({got, cr, ce, dr, de} !== 5'b10010 || drd !== e.rdata) begin
      nFails++;
      $display("[TB] FAIL dma_resp: flags=%b rdata=%h expected 10010 %h", {got, cr, ce, dr, de}, drd, e.rdata);
    end
    @(negedge clk);
    d_ren = 1; d_addr = 32'h504;
    expQ.push_back(exp_t'{own: OWN_DMA, err: 1'b1, wr: 1'b0, addr: 32'h504, wdata: 32'h0, rdata: 32'h5555_AAAA});
    serveMem(-1, 32'h0);
    nChecks++;
    if (seen !== 1'b1 || addr !== 32'h504) begin
      nFails++;
      $display("[TB] FAIL to_cmd: seen=%b addr=%h expected 1 504", seen, addr);
    end
    errAt = 0; early = 0; renAtErr = 1'bx;
    got = 0; cr = 0; ce = 0; dr = 0; de = 0; drd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (c_ready || c_err || d_ready || d_err) begin
        errAt = i; got = 1; cr = c_ready; ce = c_err; dr = d_ready; de = d_err;
        drd = d_rdata; renAtErr = mem_ren;
        break;
      end
      if (!mem_ren) early = 1;
    end
    d_ren = 0;
    e = expQ.pop_front();
    nChecks++;
    if (errAt !== TO) begin
      nFails++;
      $display("[TB] FAIL to_delay: err after %0d BUSY cycles expected %0d", errAt, TO);
    end
    nChecks++;
    if ({got, cr, ce, dr, de} !== 5'b10001) begin
      nFails++;
      $display("[TB] FAIL to_flags: got/cr/ce/dr/de=%b expected 10001", {got, cr, ce, dr, de});
    end
    nChecks++;
    if (drd !== e.rdata || renAtErr !== 1'b0 || early !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL to_state: rdata=%h ren=%b early_drop=%b expected %h 0 0", drd, renAtErr, early, e.rdata);
    end
    @(negedge clk);
    nChecks++;
    if (d_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL to_pulse: d_err=%b expected 0", d_err);
    end
  endtask

  task automatic test_reset_busy();
    applyReset();
    c_ren = 1; c_addr = 32'h600; c_bsel = 4'hF;
    serveMem(-1, 32'h0);
    nChecks++;
    if (seen !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL rst_busy_cmd: seen=%b expected 1", seen);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    nChecks++;
    if ({mem_ren, mem_wen, c_ready, c_err, d_ready, d_err, owner} !== 7'b0 || mem_addr !== '0) begin
      nFails++;
      $display("[TB] FAIL rst_busy_clear: ctrl=%b addr=%h expected 0000000 0",
               {mem_ren, mem_wen, c_ready, c_err, d_ready, d_err, owner}, mem_addr);
    end
    reset = 0; c_ren = 0;
    mem_ready = 1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ready = 0;
    nChecks++;
    if ({c_ready, c_err, d_ready, d_err, mem_ren} !== 5'b0 || c_rdata !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL rst_stale_ready: cr/ce/dr/de/ren=%b c_rdata=%h expected 00000 0",
               {c_ready, c_err, d_ready, d_err, mem_ren}, c_rdata);
    end
    repeat (2) @(negedge clk);
    nChecks++;
    if ({c_ready, d_ready, mem_ren, mem_wen} !== 4'b0) begin
      nFails++;
      $display("[TB] FAIL rst_quiet: cr/dr/ren/wen=%b expected 0000", {c_ready, d_ready, mem_ren, mem_wen});
    end
  endtask

  task automatic test_dma_after_busy();
    applyReset();
    c_ren = 1; c_addr = 32'h700; c_bsel = 4'hF;
    expQ.push_back(exp_t'{own: OWN_CPU, err: 1'b0, wr: 1'b0, addr: 32'h700, wdata: 32'h0, rdata: 32'h1111_2222});
    serveMem(-1, 32'h0);
    nChecks++;
    if (seen !== 1'b1 || own !== OWN_CPU || addr !== 32'h700) begin
      nFails++;
      $display("[TB] FAIL late_cpu_cmd: seen=%b own=%b addr=%h expected 1 0 700", seen, own, addr);
    end
    d_ren = 1; d_addr = 32'h800; d_bsel = 4'h5;
    expQ.push_back(exp_t'{own: OWN_DMA, err: 1'b0, wr: 1'b0, addr: 32'h800, wdata: 32'h0, rdata: 32'h3333_4444});
    @(negedge clk);
    nChecks++;
    if (mem_addr !== 32'h700 || owner !== OWN_CPU || mem_ren !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL late_no_switch: addr=%h owner=%b ren=%b expected 700 0 1", mem_addr, owner, mem_ren);
    end
    mem_ready = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ready = 0;
    for (int k = 0; k < 2; k++) begin
      waitResp();
      if (k == 0) c_ren = 0;
      else        d_ren = 0;
      e = expQ.pop_front();
      expFlags = {1'b1, (e.own == OWN_CPU) && !e.err, (e.own == OWN_CPU) && e.err,
                        (e.own == OWN_DMA) && !e.err, (e.own == OWN_DMA) && e.err};
      obsRd = (e.own == OWN_CPU) ? crd : drd;
      nChecks++;
      if ({got, cr, ce, dr, de} !== expFlags || obsRd !== e.rdata) begin
        nFails++;
        $display("[TB] FAIL late_resp%0d: flags=%b rdata=%h expected %b %h",
                 k, {got, cr, ce, dr, de}, obsRd, expFlags, e.rdata);
      end
      if (k == 0) begin
        serveMem(1, 32'h3333_4444);
        nChecks++;
        if (seen !== 1'b1 || own !== OWN_DMA || addr !== expQ[0].addr || bsel !== 4'h5) begin
          nFails++;
          $display("[TB] FAIL late_dma_cmd: seen=%b own=%b addr=%h bsel=%h expected 1 1 %h 5",
                   seen, own, addr, bsel, expQ[0].addr);
        end
      end
    end
    nChecks++;
    if (crd !== 32'h1111_2222) begin
      nFails++;
      $display("[TB] FAIL late_cpu_hold: c_rdata=%h expected 11112222", crd);
    end
  endtask

  initial begin
    reset = 0;
    c_ren = 0; c_wen = 0; c_addr = '0; c_wdata = '0; c_bsel = '0;
    d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_bsel = '0;
    mem_ready = 0; mem_rdata = '0;
    lastModel = OWN_DMA;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_tie();
    test_timeout();
    test_reset_busy();
    test_dma_after_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, request/memory address width.
REQ-002 SHALL have parameter TIMEOUT, 255, max cycles to wait for mem_ready before abort (1..65535).
REQ-003 SHALL have port clk input 1, single clock for all logic.
REQ-004 SHALL have port reset input 1, synchronous active-high reset.
REQ-005 SHALL have ports c_ren/c_wen input 1 each, CPU data-port read/write request.
REQ-006 SHALL have ports c_addr input ADDR_W, c_wdata input 32, c_bsel input 4, CPU request payload.
REQ-007 SHALL have ports c_rdata output 32, c_ready output 1, c_err output 1, CPU response.
REQ-008 SHALL have ports d_ren/d_wen/d_addr/d_wdata/d_bsel/d_rdata/d_ready/d_err, DMA requester, same widths/directions as CPU set.
REQ-009 SHALL have ports mem_ren/mem_wen output 1, mem_addr output ADDR_W, mem_wdata output 32, mem_bsel output 4, shared memory command.
REQ-010 SHALL have ports mem_rdata input 32, mem_ready input 1, shared memory response.
REQ-011 SHALL have port owner output 1, current grant (0 CPU, 1 DMA), valid while busy.

Function
REQ-012 SHALL implement states IDLE, BUSY, RESP; IDLE->BUSY on any pending request, BUSY->RESP on mem_ready or timeout, RESP->IDLE unconditionally.
REQ-013 SHALL sample requests in IDLE at cycle N and drive registered mem_* command from cycle N+1 until mem_ready seen.
REQ-014 SHALL treat ren and wen asserted together by one requester as a write.
REQ-015 SHALL capture mem_rdata on the mem_ready cycle and present it on the owner's *_rdata with a one-cycle *_ready pulse in RESP; minimum request-to-ready latency 3 cycles.
REQ-016 SHALL hold *_rdata stable until that requester's next completion.
REQ-017 SHALL require requesters to hold request and payload stable until their ready or err pulse; changes mid-transaction SHALL be ignored.
REQ-018 SHALL deassert mem_ren/mem_wen in RESP and IDLE; never both asserted.
REQ-019 SHALL count BUSY cycles; on reaching TIMEOUT without mem_ready, deassert command, pulse owner's *_err (not *_ready) in RESP, rdata unchanged.
REQ-020 SHALL ignore mem_ready outside BUSY.
REQ-021 SHALL never assert ready/err to the non-owning requester.
REQ-022 SHALL resolve simultaneous CPU and DMA requests per REQ-027/028.
REQ-023 SHALL re-arbitrate only in IDLE; a request arriving during BUSY/RESP waits.

Reset
REQ-024 SHALL, on reset (also mid-transaction), go to IDLE, clear timeout counter, drive all mem_*, *_ready, *_err, owner to 0 and *_rdata to 0 next cycle.
REQ-025 SHALL set the round-robin last-owner pointer to DMA on reset so CPU wins the first tie.

Configuration
REQ-026 SHALL use macro MEM_ARB_RR_EN.
REQ-027 SHALL, with MEM_ARB_RR_EN defined, grant ties to the requester not served last; pointer updated on every completion or timeout.
REQ-028 SHALL, without MEM_ARB_RR_EN, grant ties always to CPU; pointer logic absent.

Structure
REQ-029 SHALL place state encoding (IDLE/BUSY/RESP) and owner constants (OWN_CPU, OWN_DMA) in shared package mem_arb_pkg.
REQ-030 SHALL implement grant selection in sub-module mem_arb_pick (inputs: two request flags, last owner; output: winner, valid).

Verification
REQ-031 CPU read 0x100, mem_ready 2 cycles after mem_ren, mem_rdata 0xDEADBEEF -> c_ready pulse once, c_rdata 0xDEADBEEF, d_ready stays 0.
REQ-032 CPU and DMA write same cycle, RR on -> CPU first, then DMA, then CPU on next tie; RR off -> CPU every tie.
REQ-033 DMA read, mem_ready never asserted, TIMEOUT=8 -> d_err pulse 8 BUSY cycles after mem_ren, d_ready 0, mem_ren dropped.
REQ-034 c_ren and c_wen both high, c_wdata 0x12345678, c_bsel 0xF -> mem_wen 1, mem_ren 0, mem_wdata 0x12345678.
REQ-035 Reset asserted in BUSY -> next cycle IDLE, all mem_*, ready, err 0; stale mem_ready after reset ignored.
REQ-036 DMA request raised during CPU BUSY -> DMA granted only after CPU c_ready, mem_addr switches to d_addr.
